// File: rtl/fmm_reduce_sched.sv
// fmm_reduce_sched
//   Job scheduler for the fmm reduce kernel. A job (rows, cols,
//   debug_capacity) is accepted through an ap_ctrl_chain handshake and
//   validated against the kernel limits. A valid job is walked in
//   row-major order, one element command per (row, col). After the last
//   column of each row the scheduler waits for that row's acknowledge
//   from the reducer before it starts the next row.
//
// Ports
//   ap_clk, ap_rst_n          clock, async active-low reset
//   ap_start / ap_done / ap_continue / ap_idle / ap_ready
//                             ap_ctrl_chain control; done is held until continue
//   rows, cols, debug_capacity signed job descriptor, sampled on start accept
//   cmd_din/cmd_write/cmd_full_n  element command FIFO write side
//                             {last, eol, row[IDX_W], col[IDX_W]}
//   ack_empty_n/ack_read      row acknowledge FIFO read side
//   cfg_ok, cap_ok            validation flags of the current/last job
//   elems_issued              commands pushed in the current/last job
module fmm_reduce_sched #(
  parameter int IDX_W     = 17,
  parameter int MAX_ELEMS = 65536,
  parameter int MAX_CAP   = 4096
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  input  logic                    ap_continue,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic signed [31:0]      rows,
  input  logic signed [31:0]      cols,
  input  logic signed [31:0]      debug_capacity,
  output logic [2*IDX_W+1:0]      cmd_din,
  input  logic                    cmd_full_n,
  output logic                    cmd_write,
  input  logic                    ack_empty_n,
  output logic                    ack_read,
  output logic                    cfg_ok,
  output logic                    cap_ok,
  output logic [31:0]             elems_issued
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_ROW, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic               cfg_ok_q, cfg_ok_d;
  logic               cap_ok_q, cap_ok_d;
  logic [31:0]        elems_q, elems_d;
  logic [IDX_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   col_q, col_d;
  logic signed [31:0] rows_q, rows_d;
  logic signed [31:0] cols_q, cols_d;
  logic signed [31:0] cap_q, cap_d;

  // Shape/capacity checks on the latched descriptor. The product is formed
  // at 64 bits so large operands cannot overflow into a small legal value;
  // the rows>=1 / cols>=1 terms reject negative*negative.
  logic signed [63:0] prod;
  logic               cfg_chk, cap_chk;

  assign prod    = $signed({{32{rows_q[31]}}, rows_q}) * $signed({{32{cols_q[31]}}, cols_q});
  assign cfg_chk = (rows_q >= 32'sd1) && (cols_q >= 32'sd1) && (prod <= $signed(64'(MAX_ELEMS)));
  assign cap_chk = (cap_q >= 32'sd0) && (cap_q <= $signed(32'(MAX_CAP)));

  // Row/col compared zero-extended against count-1. Only meaningful once
  // the job passed validation, so counts are known to be >= 1.
  logic [31:0] row_w, col_w, rows_m1, cols_m1;
  logic        eol, last_row, last;

  assign row_w    = {{(32-IDX_W){1'b0}}, row_q};
  assign col_w    = {{(32-IDX_W){1'b0}}, col_q};
  assign rows_m1  = rows_q - 32'sd1;
  assign cols_m1  = cols_q - 32'sd1;
  assign eol      = (col_w == cols_m1);
  assign last_row = (row_w == rows_m1);
  assign last     = eol & last_row;

  always_comb begin
    state_d   = state_q;
    done_d    = done_q & ~ap_continue;
    cfg_ok_d  = cfg_ok_q;
    cap_ok_d  = cap_ok_q;
    elems_d   = elems_q;
    row_d     = row_q;
    col_d     = col_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    cap_d     = cap_q;
    cmd_write = 1'b0;
    ack_read  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A held done blocks new work until the host consumes it.
        if (ap_start && !done_q) begin
          rows_d   = rows;
          cols_d   = cols;
          cap_d    = debug_capacity;
          elems_d  = '0;
          row_d    = '0;
          col_d    = '0;
          cfg_ok_d = 1'b0;
          cap_ok_d = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        cfg_ok_d = cfg_chk;
        cap_ok_d = cap_chk;
        state_d  = (cfg_chk && cap_chk) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        cmd_write = cmd_full_n;
        if (cmd_full_n) begin
          elems_d = elems_q + 32'd1;
          if (eol) begin
            col_d   = '0;
            state_d = S_WAIT_ROW;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_WAIT_ROW: begin
        ack_read = ack_empty_n;
        if (ack_empty_n) begin
          if (last_row) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        // continue in the DONE cycle itself consumes the completion at once
        done_d  = ~ap_continue;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      cfg_ok_q <= 1'b0;
      cap_ok_q <= 1'b0;
      elems_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      cap_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      cfg_ok_q <= cfg_ok_d;
      cap_ok_q <= cap_ok_d;
      elems_q  <= elems_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      cap_q    <= cap_d;
    end
  end

  assign ap_done      = (state_q == S_DONE) | done_q;
  assign ap_ready     = (state_q == S_DONE);
  assign ap_idle      = (state_q == S_IDLE) & ~ap_start;
  // Command word only carries data while issuing; it is built from
  // registers, so it stays stable across a full_n stall.
  assign cmd_din      = (state_q == S_ISSUE) ? {last, eol, row_q, col_q} : '0;
  assign cfg_ok       = cfg_ok_q;
  assign cap_ok       = cap_ok_q;
  assign elems_issued = elems_q;

endmodule

// File: tb/tb_fmm_reduce_sched.sv
module tb_fmm_reduce_sched;
  localparam int IDX_W = 17;
  localparam int CW    = 2*IDX_W+2;

  logic ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0, ap_continue = 1'b0;
  logic cmd_full_n = 1'b1, ack_empty_n = 1'b0;
  logic signed [31:0] rows = '0, cols = '0, dcap = '0;
  logic ap_done, ap_idle, ap_ready, cmd_write, ack_read, cfg_ok, cap_ok;
  logic [CW-1:0] cmd_din;
  logic [31:0]   elems_issued;

  int errors = 0, checks = 0;
  bit full_rand = 0, ack_auto = 1;
  int ack_pend = 0, n_ack = 0;
  logic [CW-1:0] got_q[$];

  fmm_reduce_sched dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .rows(rows), .cols(cols), .debug_capacity(dcap),
    .cmd_din(cmd_din), .cmd_full_n(cmd_full_n), .cmd_write(cmd_write),
    .ack_empty_n(ack_empty_n), .ack_read(ack_read),
    .cfg_ok(cfg_ok), .cap_ok(cap_ok), .elems_issued(elems_issued)
  );

  always #5 ap_clk = ~ap_clk;

  // Stream monitor: records every push and tracks outstanding row acks.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) ack_pend = 0;
    else begin
      if (cmd_write) begin
        got_q.push_back(cmd_din);
        if (cmd_din[2*IDX_W]) ack_pend++;
      end
      if (ack_read) begin
        n_ack++;
        ack_pend--;
      end
    end
  end

  // Reducer model: acknowledges a row the cycle after its eol is pushed.
  always @(posedge ap_clk) begin
    #1;
    if (ack_auto) ack_empty_n = (ack_pend > 0);
    if (full_rand) cmd_full_n = ($urandom_range(0, 3) != 0);
  end

  function automatic bit exp_cfg(int r, int c);
    longint p;
    p = longint'(r) * longint'(c);
    return (r >= 1) && (c >= 1) && (p <= 65536);
  endfunction

  function automatic bit exp_cap(int d);
    return (d >= 0) && (d <= 4096);
  endfunction

  task automatic start_job(input int r, input int c, input int d);
    @(posedge ap_clk); #1;
    rows = r; cols = c; dcap = d; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k, output bit to);
    k = 0; to = 1'b1;
    while (k < budget) begin
      @(negedge ap_clk);
      k++;
      if (ap_done) begin to = 1'b0; break; end
    end
  endtask

  task automatic clear_done();
    @(posedge ap_clk); #1; ap_continue = 1'b1;
    @(posedge ap_clk); #1; ap_continue = 1'b0;
  endtask

  task automatic check_job(input int r, input int c, input int d, input int k,
                           input bit to, input bit timing, input string nm);
    logic [CW-1:0] exp_q[$];
    logic [IDX_W-1:0] ri, ci;
    bit v;
    int n, bad, ek;
    v = exp_cfg(r, c) && exp_cap(d);
    if (v) for (int i = 0; i < r; i++) for (int j = 0; j < c; j++) begin
      ri = i[IDX_W-1:0]; ci = j[IDX_W-1:0];
      exp_q.push_back({(j == c-1) && (i == r-1), (j == c-1), ri, ci});
    end
    n = v ? r*c : 0;
    checks++;
    if (to) begin errors++; $display("FAIL %s done_timeout: done not seen in %0d cycles", nm, k); end
    checks++;
    if (cfg_ok !== exp_cfg(r, c)) begin errors++; $display("FAIL %s cfg_ok: got %b want %b", nm, cfg_ok, exp_cfg(r, c)); end
    checks++;
    if (cap_ok !== exp_cap(d)) begin errors++; $display("FAIL %s cap_ok: got %b want %b", nm, cap_ok, exp_cap(d)); end
    checks++;
    if (elems_issued !== 32'(n)) begin errors++; $display("FAIL %s elems_issued: got %0d want %0d", nm, elems_issued, n); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s push_count: got %0d want %0d", nm, got_q.size(), exp_q.size()); end
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin bad = i; break; end
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL %s cmd_seq[%0d]: got %h want %h", nm, bad, got_q[bad], exp_q[bad]); end
    checks++;
    if (n_ack != (v ? r : 0)) begin errors++; $display("FAIL %s ack_reads: got %0d want %0d", nm, n_ack, v ? r : 0); end
    if (timing) begin
      ek = v ? 2 + r*(c+1) : 2;
      checks++;
      if (k != ek) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", nm, k, ek); end
    end
  endtask

  task automatic do_job(input int r, input int c, input int d, input int budget,
                        input bit timing, input string nm);
    int k; bit to;
    got_q.delete(); n_ack = 0;
    start_job(r, c, d);
    wait_done(budget, k, to);
    check_job(r, c, d, k, to, timing, nm);
    clear_done();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({ap_done, ap_ready, cmd_write, ack_read, cfg_ok, cap_ok, ap_idle} !== 7'b0000001) begin
      errors++; $display("FAIL reset_ctl: got %b want 0000001",
        {ap_done, ap_ready, cmd_write, ack_read, cfg_ok, cap_ok, ap_idle});
    end
    checks++;
    if (elems_issued !== 32'd0) begin errors++; $display("FAIL reset_elems: got %0d want 0", elems_issued); end
    @(negedge ap_clk); ap_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int k; bit to; bit held_bad;
    got_q.delete(); n_ack = 0;
    start_job(2, 3, 100);
    wait_done(100, k, to);
    check_job(2, 3, 100, k, to, 1'b1, "basic");
    checks++;
    if (ap_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", ap_ready); end
    held_bad = 1'b0;
    repeat (4) begin
      @(negedge ap_clk);
      if (ap_done !== 1'b1 || ap_ready !== 1'b0) held_bad = 1'b1;
    end
    checks++;
    if (held_bad) begin errors++; $display("FAIL basic_done_hold: done/ready got %b%b want 10", ap_done, ap_ready); end
    clear_done();
    @(negedge ap_clk);
    checks++;
    if (ap_done !== 1'b0) begin errors++; $display("FAIL basic_continue: done got %b want 0", ap_done); end
  endtask

  task automatic test_limits();
    do_job(256, 256, 0, 70000, 1'b1, "limit_ok");
    do_job(256, 257, 0, 100, 1'b1, "limit_over");
  endtask

  task automatic test_sign_cap();
    do_job(-1, -1, 100, 100, 1'b1, "neg_neg");
    do_job(2, 2, 4096, 100, 1'b1, "cap_max");
    do_job(2, 2, 4097, 100, 1'b1, "cap_over");
    do_job(2, 2, -1, 100, 1'b1, "cap_neg");
    do_job(0, 5, 10, 100, 1'b1, "rows_zero");
    do_job(1, 65536, 10, 70000, 1'b1, "one_row_max");
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] held, exp_h;
    bit bad_wr, bad_stab, to;
    int done_k, nack_hold, k;
    got_q.delete(); n_ack = 0;
    bad_wr = 0; bad_stab = 0; done_k = 0; held = '0;
    start_job(1, 4, 10);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) begin @(posedge ap_clk); #1; end
      cmd_full_n = !(c >= 3 && c <= 5);
      @(negedge ap_clk);
      if (!cmd_full_n && cmd_write) bad_wr = 1;
      if (c == 3) held = cmd_din;
      if ((c == 4 || c == 5) && cmd_din !== held) bad_stab = 1;
      if (ap_done) begin done_k = c; break; end
    end
    cmd_full_n = 1'b1;
    exp_h = {1'b0, 1'b0, 17'd0, 17'd1};
    checks++;
    if (bad_wr) begin errors++; $display("FAIL bp_write_while_full: got write want none"); end
    checks++;
    if (bad_stab || held !== exp_h) begin errors++; $display("FAIL bp_din_stable: got %h want %h", held, exp_h); end
    checks++;
    if (done_k != 10) begin errors++; $display("FAIL bp_done_cycle: got %0d want 10", done_k); end
    check_job(1, 4, 10, done_k, done_k == 0, 1'b0, "bp");
    clear_done();

    // Withhold the row acknowledge: block must sit in WAIT_ROW.
    ack_auto = 1'b0; ack_empty_n = 1'b0;
    got_q.delete(); n_ack = 0; nack_hold = 0;
    start_job(1, 2, 10);
    for (int c = 1; c <= 14; c++) begin
      @(negedge ap_clk);
      if (ack_read || ap_done || (c > 3 && cmd_write)) nack_hold++;
    end
    checks++;
    if (nack_hold != 0 || got_q.size() != 2) begin
      errors++; $display("FAIL ack_hold: got %0d events %0d pushes want 0 events 2 pushes", nack_hold, got_q.size());
    end
    @(posedge ap_clk); #1; ack_auto = 1'b1;
    wait_done(20, k, to);
    check_job(1, 2, 10, k, to, 1'b0, "ack_hold");
    clear_done();
  endtask

  task automatic test_chaining();
    int k; bit to; bit bad;
    got_q.delete(); n_ack = 0;
    start_job(1, 1, 0);
    wait_done(50, k, to);
    check_job(1, 1, 0, k, to, 1'b1, "chain1");
    got_q.delete(); n_ack = 0;
    @(posedge ap_clk); #1;
    rows = 1; cols = 2; dcap = 0; ap_start = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge ap_clk);
      if (cmd_write || !ap_done || elems_issued !== 32'd1) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL chain_blocked: got new job activity want none while done held"); end
    @(posedge ap_clk); #1; ap_continue = 1'b1;
    @(posedge ap_clk); #1; ap_continue = 1'b0;
    @(posedge ap_clk); #1; ap_start = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (ap_done !== 1'b0 || elems_issued !== 32'd0 || ap_idle !== 1'b0) begin
      errors++; $display("FAIL chain_restart: done=%b elems=%0d idle=%b want 0 0 0", ap_done, elems_issued, ap_idle);
    end
    wait_done(50, k, to);
    check_job(1, 2, 0, k, to, 1'b0, "chain2");
    clear_done();
  endtask

  task automatic test_continue_in_done();
    got_q.delete(); n_ack = 0;
    start_job(0, 3, 5);
    @(posedge ap_clk); #1; ap_continue = 1'b1;
    @(negedge ap_clk);
    checks++;
    if ({ap_done, ap_ready} !== 2'b11) begin errors++; $display("FAIL cid_done_cycle: got %b want 11", {ap_done, ap_ready}); end
    @(posedge ap_clk); #1; ap_continue = 1'b0;
    @(negedge ap_clk);
    checks++;
    if ({ap_done, ap_ready, ap_idle, cfg_ok} !== 4'b0010 || got_q.size() != 0) begin
      errors++; $display("FAIL cid_after: got %b pushes %0d want 0010 pushes 0",
        {ap_done, ap_ready, ap_idle, cfg_ok}, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); n_ack = 0;
    start_job(3, 3, 50);
    repeat (3) @(negedge ap_clk);
    checks++;
    if (cmd_write !== 1'b1) begin errors++; $display("FAIL rst_mid_issuing: cmd_write got %b want 1", cmd_write); end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({ap_done, ap_ready, cmd_write, ack_read, cfg_ok, cap_ok} !== 6'b0 ||
        elems_issued !== 32'd0 || cmd_din !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: ctl=%b elems=%0d din=%h want all 0",
        {ap_done, ap_ready, cmd_write, ack_read, cfg_ok, cap_ok}, elems_issued, cmd_din);
    end
    @(negedge ap_clk);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    do_job(2, 2, 7, 100, 1'b1, "post_reset");
  endtask

  task automatic test_random();
    int r, c, d;
    bit bp;
    for (int n = 0; n < 12; n++) begin
      r = int'($urandom_range(0, 7)) - 1;
      c = int'($urandom_range(0, 7)) - 1;
      case ($urandom_range(0, 4))
        0: d = -1;
        1: d = 0;
        2: d = 4096;
        3: d = 4097;
        default: d = int'($urandom_range(0, 5000));
      endcase
      bp = $urandom_range(0, 1) != 0;
      full_rand = bp;
      do_job(r, c, d, 2000, !bp, "random");
      full_rand = 1'b0;
      @(posedge ap_clk); #2; cmd_full_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_cap();
    test_backpressure();
    test_chaining();
    test_continue_in_done();
    test_reset_mid();
    test_random();
    test_limits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fmm_reduce_sched.md
Name: fmm_reduce_sched

Overview:
- Block-level scheduler for the fmm reduce kernel. Accepts a job (rows, cols, debug_capacity) through an ap_ctrl_chain-style handshake and validates it with the kernel's limits.
- For a valid job, issues one element command per (row, col) in row-major order on a FIFO-style command stream. After each row it blocks until the reducer returns that row's acknowledge.
- Reports the validation flags and issued-element count on completion. Sits between the top-level control and the reduce datapath.

Parameters:
- IDX_W, 17, width of the row and col index fields; must hold 65536.
- MAX_ELEMS, 65536, maximum legal rows*cols (inclusive).
- MAX_CAP, 4096, maximum legal debug_capacity (inclusive).

Ports:
- ap_clk  in  1  clock; all state on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  job request.
- ap_done  out  1  job complete; held until ap_continue.
- ap_continue  in  1  clears held done.
- ap_idle  out  1  high in IDLE when ap_start=0.
- ap_ready  out  1  one-cycle pulse in DONE.
- rows  in  32  signed row count; sampled at start.
- cols  in  32  signed column count; sampled at start.
- debug_capacity  in  32  signed capacity; sampled at start.
- cmd_din  out  2*IDX_W+2  layout: [IDX_W-1:0] col, [2*IDX_W-1:IDX_W] row, [2*IDX_W] eol, [2*IDX_W+1] last.
- cmd_full_n  in  1  downstream can accept.
- cmd_write  out  1  command push.
- ack_empty_n  in  1  row acknowledge available.
- ack_read  out  1  row acknowledge pop.
- cfg_ok  out  1  shape valid; registered.
- cap_ok  out  1  capacity valid; registered.
- elems_issued  out  32  commands pushed in the current or last job.

Behaviour:
- Reset (async, ap_rst_n=0):
  - State goes to IDLE; done_reg, cfg_ok, cap_ok, elems_issued, row/col counters all 0.
  - cmd_write=0, ack_read=0, ap_ready=0, ap_done=0.
  - Reset mid-job abandons the job; no further cmd_write or ack_read.
- IDLE:
  - On ap_start=1 and done_reg=0: latch rows/cols/debug_capacity, clear elems_issued and counters, go to CHECK.
  - ap_start is ignored while done_reg=1.
- CHECK (one cycle):
  - prod = signed 64-bit rows*cols.
  - cfg_ok <= (rows>=1) & (cols>=1) & (prod<=MAX_ELEMS). Negative*negative is rejected.
  - cap_ok <= (debug_capacity>=0) & (debug_capacity<=MAX_CAP).
  - Next state is ISSUE if both flags are 1, else DONE. No commands are issued for an invalid job.
- ISSUE:
  - cmd_write = cmd_full_n (combinational). cmd_din = {last, eol, row, col}.
  - eol = (col==cols-1). last = eol & (row==rows-1).
  - On each push: col++ and elems_issued++. When eol is pushed: col<=0, go to WAIT_ROW.
  - cmd_full_n=0 stalls with no push; cmd_din is held stable.
- WAIT_ROW:
  - ack_read = ack_empty_n.
  - On pop: if the row was the last row, go to DONE; else row++ and return to ISSUE.
  - Waits indefinitely for the acknowledge.
- DONE (one cycle):
  - ap_done=1 and ap_ready=1; done_reg <= 1 unless ap_continue=1 in the same cycle. Then go to IDLE.
  - ap_done = DONE | done_reg. done_reg clears on any cycle with ap_continue=1; ap_continue wins over set.
- Latency and status holding:
  - First cmd_write occurs 2 cycles after the start-accept cycle, when cmd_full_n=1.
  - Best-case job time is 2 + rows*(cols+1) + 1 cycles.
  - cfg_ok, cap_ok and elems_issued hold their values until the next start is accepted.
- Index widths:
  - row and col are stored IDX_W wide; a valid job never exceeds 65536, so no wrap is possible.
  - elems_issued does not wrap for legal jobs.

Test Plan:
- Basic job: rows=2, cols=3, debug_capacity=100, full_n=1, ack returned 1 cycle after each eol.
  - Required: 6 pushes (r,c) = (0,0),(0,1),(0,2)eol,(1,0),(1,1),(1,2)eol+last.
  - Required: 2 ack_read pulses, cfg_ok=1, cap_ok=1, elems_issued=6, ap_done held until ap_continue.
- Limits: rows=256, cols=256 -> cfg_ok=1, 65536 pushes. rows=256, cols=257 -> cfg_ok=0, zero pushes, done 2 cycles after start.
- Sign and capacity checks:
  - rows=-1, cols=-1 -> cfg_ok=0.
  - debug_capacity=4096 -> cap_ok=1. debug_capacity=4097 -> cap_ok=0. debug_capacity=-1 -> cap_ok=0.
  - Any failing flag -> no cmd_write.
- Backpressure: rows=1, cols=4, cmd_full_n low for cycles 3-5.
  - Required: no writes while low, cmd_din stable, order preserved, elems_issued=4.
  - ack_empty_n held low 10 cycles -> block stays in WAIT_ROW with no ack_read.
- Chaining: hold ap_start=1 with ap_continue=0 -> no second job while done is held. Pulse ap_continue -> next job starts the following cycle.
  - Assert ap_continue in the DONE cycle itself -> done_reg stays 0.
- Reset: ap_rst_n=0 asynchronously mid-ISSUE (rows=3, cols=3).
  - Required: cmd_write drops immediately and all outputs are 0.
  - A new job after release behaves as from power-on.
